// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between NUM_REQ requesters.
// Registers the winning operation onto the ALU bus and routes results back via a tag pipeline.
module alu_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 16,
  parameter int ALU_LATENCY = 1,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*4-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [3:0]                alu_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_y,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        win;
  logic                   found;
  logic                   accept;
  logic [ID_W:0]          tgt;
  logic [3:0]             sel_op;
  logic [DATA_W-1:0]      sel_a;
  logic [DATA_W-1:0]      sel_b;

  // Stage 0 is the issue stage; stage ALU_LATENCY is the response stage.
  logic [ALU_LATENCY:0]   tag_vld;
  logic [ID_W-1:0]        tag_id [ALU_LATENCY+1];

  always_comb begin
    found  = 1'b0;
    win    = '0;
    tgt    = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      tgt = {1'b0, ptr} + (ID_W+1)'(k);
      if (tgt >= (ID_W+1)'(NUM_REQ)) tgt = tgt - (ID_W+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (tgt == (ID_W+1)'(i))) begin
          found  = 1'b1;
          win    = ID_W'(i);
          sel_op = req_op[4*i +: 4];
          sel_a  = req_a[DATA_W*i +: DATA_W];
          sel_b  = req_b[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  // Gating with resetn keeps grants off while reset is held.
  assign accept = found & resetn;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (win == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr      <= '0;
      alu_ctrl <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      tag_vld  <= '0;
      for (int s = 0; s <= ALU_LATENCY; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld   <= {tag_vld[ALU_LATENCY-1:0], accept};
      tag_id[0] <= accept ? win : '0;
      for (int s = 1; s <= ALU_LATENCY; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
      if (accept) begin
        alu_ctrl <= sel_op;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        ptr      <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_id    = '0;
    rsp_data  = '0;
    if (tag_vld[ALU_LATENCY]) begin
      rsp_id   = tag_id[ALU_LATENCY];
      rsp_data = alu_y;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] = (tag_id[ALU_LATENCY] == ID_W'(i));
      end
    end
  end

  assign busy = |tag_vld;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one pipelined ALU instance between NUM_REQ independent requesters (decode/execute ports, address-generation, debug).
- Round-robin arbitration among valid requests, at most one issue per cycle.
- Registers the winning operation onto the ALU input bus.
- Tracks in-flight operations with a tag pipeline and returns each result to its requester with a one-hot valid and a requester ID.
- Sits between the issue logic and the ALU; the ALU's ctrl/a/b/y connect directly to this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); ID_W = max(1, clog2(NUM_REQ)), derived
- DATA_W, 16, operand/result width
- ALU_LATENCY, 1, cycles from ALU input edge to valid y (1..4, must match ALU)

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_op  in  NUM_REQ*4  per-requester ALU opcode (ALU_OP_* encoding), slice i = [4i+3:4i]
- req_a  in  NUM_REQ*DATA_W  per-requester operand a
- req_b  in  NUM_REQ*DATA_W  per-requester operand b
- alu_ctrl  out  4  registered opcode to ALU
- alu_a  out  DATA_W  registered operand a to ALU
- alu_b  out  DATA_W  registered operand b to ALU
- alu_y  in  DATA_W  ALU result
- rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle, no backpressure
- rsp_id  out  ID_W  requester index of current response
- rsp_data  out  DATA_W  result (= alu_y when any rsp_valid)
- busy  out  1  high while any operation is in flight

Behaviour:
- Reset (async assert, sync release):
  - alu_ctrl/a/b = 0; rsp_valid = 0; rsp_id = 0; busy = 0.
  - All in-flight tags cleared; round-robin pointer = 0 (requester 0 highest priority).
- Arbitration:
  - Combinational. Search starts at pointer ptr, wraps modulo NUM_REQ; the first i with req_valid[i] wins.
  - req_ready = one-hot of the winner; all zero if no req_valid.
  - req_ready never asserted during reset.
- Accept: a transfer occurs on a rising edge when req_valid[i] & req_ready[i]. Requesters must hold op/a/b stable while valid and not ready.
- On accept from requester i:
  - alu_ctrl/a/b <= req_op[i]/req_a[i]/req_b[i] (issue stage).
  - ptr <= (i+1) mod NUM_REQ.
  - Tag (valid=1, id=i) enters a tag shift register of depth ALU_LATENCY+1.
- No accept: alu_ctrl/a/b hold previous values (no toggling), tag entry valid=0, ptr unchanged.
- Work-conserving: a lone requester is granted every cycle, giving back-to-back issue with full throughput.
- Latency:
  - Accept edge E: operands at ALU from E, result valid at alu_y after edge E+ALU_LATENCY.
  - rsp_valid[id] high for exactly the one cycle following edge E+ALU_LATENCY, i.e. ALU_LATENCY+1 cycles after the request cycle.
  - rsp_data = alu_y; rsp_id = tag id.
  - When no response: rsp_data = 0, rsp_id = 0.
- Ordering: responses return in issue order; one response max per cycle.
- busy = OR of all tag valid bits (issue stage through response stage).
- Simultaneous events:
  - All requesters valid: strict rotation, each granted once per NUM_REQ cycles.
  - A new accept in the same cycle a response retires is allowed.
- Width: data passes through unmodified; no arithmetic in this block. Unused requester slices are ignored.
- Reset mid-operation: all in-flight tags discarded, no rsp_valid for them after reset release; ALU output is don't-care until a new issue.

Test Plan:
- Single requester (NUM_REQ=2, LATENCY=1): req0 ADD a=0x002a b=0x002a at cycle 1 -> req_ready[0]=1 in cycle 1; alu_ctrl=ALU_OP_ADD, a=b=0x002a after edge; rsp_valid=2'b01, rsp_id=0, rsp_data=0x0054 two cycles after request; busy high for exactly 2 cycles.
- Contention: both valid continuously, req0 SUB 3-5, req1 MUL 3*4 -> grants alternate 0,1,0,1; responses alternate 0xfffe (id 0) and 0x000c (id 1), one per cycle, no gaps.
- Round-robin fairness after idle: req1 granted alone, then both valid -> req0 granted next (ptr=0), then req1.
- Back-to-back single requester: req1 valid 8 cycles with XOR 3^4, then ADD 1+0xffff -> 8 consecutive accepts; 8 consecutive rsp_valid=2'b10; wrap result 0x0000 delivered correctly.
- Hold-off: req0 valid while req1 granted -> req0 op/a/b held stable; alu_* unchanged in cycles with no accept; req0 served next cycle.
- Reset mid-flight: assert resetn=0 one cycle after accept -> rsp_valid stays 0, busy=0, alu_* = 0 immediately (async); after release, first request gets normal latency with ptr=0.
